// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between the ioctl
// download path (strobed writes, one-entry buffer) and the system-side
// SRAM-style port (level-based CE/OE/WE).
//
// Handshake with the controller: an access is issued by a one-cycle pulse on
// mem_we or mem_rd while mem_addr/mem_din are valid. mem_addr/mem_din are held
// until the arbiter is back in IDLE. The controller signals it has taken the
// access by dropping mem_ready and signals completion by raising it again. A
// controller that never drops mem_ready is treated as having finished once
// BUSY_TO wait cycles have elapsed.
// System-side handshake: the request is held level-high (CE low plus OE or
// WE low). sram_rdy rises once the access has finished and stays high until
// the strobe or CE is released.
module sdram_port_arbiter #(
  parameter int AW      = 23,
  parameter int DW      = 8,
  parameter int BUSY_TO = 7
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_data,
  input  logic          sram_ce_n,
  input  logic          sram_oe_n,
  input  logic          sram_we_n,
  input  logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_d,
  output logic [DW-1:0] sram_q,
  output logic          sram_rdy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ready,
  output logic          ovf,
  output logic [1:0]    dbg_state
);

  localparam int CW = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_TO);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          buf_valid_q, buf_valid_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [DW-1:0] buf_data_q, buf_data_d;
  logic          ovf_q, ovf_d;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_rd_q, mem_rd_d;
  logic          src_sys_q, src_sys_d;   // current access came from the system port
  logic          op_rd_q, op_rd_d;       // current access is a read

  logic          sys_done_q, sys_done_d;
  logic [DW-1:0] sram_q_q, sram_q_d;

  logic          strobe_on;
  logic          sys_req;
  logic          buf_issue;
  logic          complete;

  // System strobe decode and download-buffer issue detection.
  always_comb begin
    strobe_on = !sram_ce_n && (!sram_oe_n || !sram_we_n);
    sys_req   = strobe_on && !sys_done_q && !ioctl_download;
    buf_issue = (state_q == S_ISSUE) && !src_sys_q;
  end

  // One-entry download buffer: capture, release on issue, sticky overflow.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    ovf_d       = ovf_q;
    if (buf_issue) begin
      buf_valid_d = 1'b0;
    end
    if (ioctl_wr) begin
      if (buf_valid_q && !buf_issue) begin
        // Buffer still owed to the controller: this write is lost.
        ovf_d = 1'b1;
      end else begin
        buf_valid_d = 1'b1;
        buf_addr_d  = ioctl_addr;
        buf_data_d  = ioctl_data;
      end
    end
  end

  // Access FSM: select a source, pulse the issue, track busy/done.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    mem_rd_d   = 1'b0;
    src_sys_d  = src_sys_q;
    op_rd_d    = op_rd_q;
    complete   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_ready) begin
          if (buf_valid_q) begin
            mem_addr_d = buf_addr_q;
            mem_din_d  = buf_data_q;
            src_sys_d  = 1'b0;
            op_rd_d    = 1'b0;
            mem_we_d   = 1'b1;
            state_d    = S_ISSUE;
          end else if (sys_req) begin
            // WE low wins over OE low: a both-low strobe is a write.
            mem_addr_d = sram_addr;
            mem_din_d  = sram_d;
            src_sys_d  = 1'b1;
            op_rd_d    = sram_we_n;
            mem_we_d   = !sram_we_n;
            mem_rd_d   = sram_we_n;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!mem_ready) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          // Controller never showed busy: assume it already finished.
          complete = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (mem_ready) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // System-side completion: latch read data and hold ready until release.
  always_comb begin
    sys_done_d = sys_done_q;
    sram_q_d   = sram_q_q;
    if (complete && src_sys_q) begin
      sys_done_d = 1'b1;
      if (op_rd_q) begin
        sram_q_d = mem_dout;
      end
    end
    if (!strobe_on) begin
      sys_done_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      ovf_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      src_sys_q   <= 1'b0;
      op_rd_q     <= 1'b0;
      sys_done_q  <= 1'b0;
      sram_q_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      ovf_q       <= ovf_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      mem_rd_q    <= mem_rd_d;
      src_sys_q   <= src_sys_d;
      op_rd_q     <= op_rd_d;
      sys_done_q  <= sys_done_d;
      sram_q_q    <= sram_q_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign mem_rd    = mem_rd_q;
  assign sram_q    = sram_q_q;
  assign sram_rdy  = sys_done_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: the ioctl download path (write-only, strobe-based) and the system-side SRAM-style port (active-low CE/OE/WE, level-based).
- Replaces the plain address/data/strobe multiplexing selected by `ioctl_download`.
- Converts both requesters into single issue/complete transactions on the controller's `we`/`rd`/`ready` interface.
- Buffers one download write, latches read data, and provides a wait-state ready to the system side.

Parameters:
- AW, 23, address width of both requesters and the memory port.
- DW, 8, data width.
- BUSY_TO, 7, cycles to wait for `mem_ready` to fall after an issue before the access is treated as already complete.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress; while high, the download side has absolute priority.
- ioctl_wr  in  1  single-cycle write strobe from the download path.
- ioctl_addr  in  AW  download write address.
- ioctl_data  in  DW  download write data.
- sram_ce_n  in  1  system chip enable, active low.
- sram_oe_n  in  1  system read enable, active low.
- sram_we_n  in  1  system write enable, active low.
- sram_addr  in  AW  system address.
- sram_d  in  DW  system write data.
- sram_q  out  DW  latched system read data.
- sram_rdy  out  1  system access complete; held until the strobe deasserts.
- mem_addr  out  AW  controller address.
- mem_din  out  DW  controller write data.
- mem_we  out  1  write issue pulse.
- mem_rd  out  1  read issue pulse.
- mem_dout  in  DW  controller read data.
- mem_ready  in  1  controller idle/done.
- ovf  out  1  sticky: a download write was lost.

Behaviour:
- **Reset (async on reset_n low):**
  - All outputs 0.
  - State IDLE; download buffer empty; `ovf` cleared.
  - A reset mid-transaction abandons it; no completion is reported.
- **Download buffer (1 entry):**
  - `ioctl_wr`=1 captures `ioctl_addr`/`ioctl_data` and sets the buffer valid.
  - If `ioctl_wr` arrives while the buffer is still valid and not being issued in that same cycle, the new write is dropped and `ovf` is set. `ovf` clears only on reset.
  - A capture and an issue of the old entry in the same cycle is legal: the buffer refills.
- **System request:**
  - `sys_req` = !`sram_ce_n` & (!`sram_oe_n` | !`sram_we_n`) & !`sys_done` & !`ioctl_download`.
  - `sys_done` sets when a system access completes and clears when `sram_ce_n`=1, or when `sram_oe_n`&`sram_we_n`=1.
  - If both OE and WE are low, the access is a write.
- **FSM states:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - **IDLE:** requires `mem_ready`=1. Buffer valid wins; otherwise `sys_req`. When one is selected, latch address/data/op into the `mem_*` registers and go to ISSUE.
  - **ISSUE:** `mem_we` or `mem_rd`=1 for exactly this one cycle. Clear the buffer if it was the source. Go to WAIT_BUSY with the timeout counter at 0.
  - **WAIT_BUSY:**
    - `mem_ready`=0 → WAIT_DONE.
    - If the counter reaches BUSY_TO with `mem_ready` still 1 → treat as complete (same actions as WAIT_DONE completion) → IDLE.
  - **WAIT_DONE:** `mem_ready`=1 → complete → IDLE.
    - For a system read, `sram_q` <= `mem_dout` on that edge.
    - For a system access, `sram_rdy`=1 from the next cycle.
- **Ordering and timing:**
  - `mem_addr`/`mem_din` stay stable from ISSUE until the return to IDLE.
  - `sram_rdy` stays 1 while `sys_done`=1, and drops in the cycle after the strobe or CE deasserts.
  - `sram_q` holds its value until the next system read completes.
- **`ioctl_download` rising mid-system-access:** the in-flight access completes normally; no new system access starts until download falls. `sram_rdy` stays 0 for any request that was not completed.
- **Minimum latency:** a download write issues 2 cycles after `ioctl_wr` (capture, IDLE, ISSUE).

Test Plan:
- **Reset mid-operation:** reset_n low during WAIT_DONE → next cycle all outputs 0, `ovf`=0; after release with `mem_ready`=1, no `mem_we`/`mem_rd` pulse until a new request.
- **Single download write:** `ioctl_download`=1, `ioctl_wr` with addr 0x000123, data 0xA5; memory model busy 4 cycles → exactly one `mem_we` pulse carrying addr 0x000123 / din 0xA5, `ovf`=0.
- **Download back-to-back and overflow:** `ioctl_wr` every 2 cycles with a model busy 6 cycles → the 3rd write is lost, `ovf`=1 and stays 1; the issued writes keep their original addresses and order.
- **System read:** `ce_n`=0, `oe_n`=0, addr 0x01FFFF, model returns 0x3C → one `mem_rd` pulse; `sram_q`=0x3C and `sram_rdy`=1 after completion; `oe_n`=1 → `sram_rdy`=0 next cycle, with no second `mem_rd`.
- **Contention:** a system write 0x55 is pending when a download write 0x99 arrives in the same cycle → the download issues first, the system write follows; exactly two `mem_we` pulses.
- **Fast controller:** `mem_ready` never falls → each access completes after BUSY_TO+1 wait cycles; a read returns the current `mem_dout`.
